// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: access-size codes, FSM states
// and status codes.
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        FSM_INIT = 1'b0,
        FSM_RUN  = 1'b1
    } dmem_state_e;

    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    // Alignment fault for a given size and byte lane; size 11 always faults.
    function automatic logic align_fault(input logic [1:0] size, input logic [1:0] lane);
        logic f;
        case (size)
            SZ_B:    f = 1'b0;
            SZ_H:    f = lane[0];
            SZ_W:    f = |lane;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: merges store data into the addressed word and
// extracts/extends load data from it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] new_word,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store merge: only the addressed lanes change, the rest of the word is kept.
    always_comb begin
        new_word = old_word;
        case (size)
            SZ_B: begin
                case (lane)
                    2'd0:    new_word[7:0]   = wdata[7:0];
                    2'd1:    new_word[15:8]  = wdata[7:0];
                    2'd2:    new_word[23:16] = wdata[7:0];
                    2'd3:    new_word[31:24] = wdata[7:0];
                    default: new_word        = old_word;
                endcase
            end
            SZ_H: begin
                if (lane[1]) begin
                    new_word[31:16] = wdata[15:0];
                end else begin
                    new_word[15:0]  = wdata[15:0];
                end
            end
            SZ_W:    new_word = wdata;
            default: new_word = old_word;
        endcase
    end

    // Lane extraction for loads.
    always_comb begin
        byte_s = 8'd0;
        case (lane)
            2'd0:    byte_s = old_word[7:0];
            2'd1:    byte_s = old_word[15:8];
            2'd2:    byte_s = old_word[23:16];
            2'd3:    byte_s = old_word[31:24];
            default: byte_s = 8'd0;
        endcase
        if (lane[1]) begin
            half_s = old_word[31:16];
        end else begin
            half_s = old_word[15:0];
        end
    end

    // Sign or zero extension of the extracted lane.
    always_comb begin
        load_data = 32'd0;
        case (size)
            SZ_B: begin
                if (is_unsigned) begin
                    load_data = {24'd0, byte_s};
                end else begin
                    load_data = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_H: begin
                if (is_unsigned) begin
                    load_data = {16'd0, half_s};
                end else begin
                    load_data = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_W:    load_data = old_word;
            default: load_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// Word-organised data memory with byte/half/word access, self-clearing init
// sequencer, per-access fault reporting and a one-cycle registered response.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rnw,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        status
);

    localparam int IDX_W = $clog2(DEPTH);
    // Address bits that may be set for an in-range access.
    localparam logic [ADDR_W-1:0] IN_RANGE_MASK = ADDR_W'(DEPTH * 4 - 1);

    logic [31:0]       mem_r [DEPTH];
    dmem_state_e       state_r, state_next_s;
    logic [IDX_W-1:0]  cnt_r, cnt_next_s;
    logic [IDX_W-1:0]  idx_s;
    logic              accept_s, fault_s;
    logic [31:0]       old_word_s, new_word_s, load_data_s;
    logic              rsp_valid_r, rsp_err_r;
    logic [31:0]       rsp_rdata_r;
    logic [1:0]        status_r;

    assign idx_s      = req_addr[IDX_W+1:2];
    assign old_word_s = mem_r[idx_s];
    assign req_ready  = (state_r == FSM_RUN);
    assign accept_s   = req_valid & req_ready;
    assign fault_s    = align_fault(req_size, req_addr[1:0]) | (|(req_addr & ~IN_RANGE_MASK));

    dmem_lane_align u_lane_align (
        .old_word    (old_word_s),
        .wdata       (req_wdata),
        .size        (req_size),
        .lane        (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .new_word    (new_word_s),
        .load_data   (load_data_s)
    );

    // Next-state logic: INIT walks the clear counter across every word, then RUN.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            FSM_INIT: begin
                cnt_next_s = cnt_r + IDX_W'(1'b1);
                if (cnt_r == IDX_W'(DEPTH - 1)) begin
                    state_next_s = FSM_RUN;
                end else begin
                    state_next_s = FSM_INIT;
                end
            end
            FSM_RUN:  state_next_s = FSM_RUN;
            default:  state_next_s = FSM_INIT;
        endcase
    end

    // FSM state and clear counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FSM_INIT;
            cnt_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Array write port: zero-fill during INIT, clean stores during RUN.
    always_ff @(posedge clk) begin
        if (state_r == FSM_INIT) begin
            mem_r[cnt_r] <= 32'd0;
        end else if (accept_s && !req_rnw && !fault_s) begin
            mem_r[idx_s] <= new_word_s;
        end
    end

    // Response and status registers; status holds between accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            status_r    <= ST_INIT;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= fault_s;
            rsp_rdata_r <= (req_rnw && !fault_s) ? load_data_s : 32'd0;
            status_r    <= fault_s ? ST_FAULT : ST_READY;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
            status_r    <= (state_r == FSM_INIT) ? ST_INIT : status_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign status    = status_r;

endmodule

// File: tb/tb_dmem_sized.sv
// Self-checking bench for dmem_sized (DEPTH=16): directed vector table, reset
// corner sequences and random traffic against a byte-array reference model.
module tb_dmem_sized;

    localparam int DEPTH = 16;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rnw = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  status;

    int checks = 0;
    int errors = 0;
    logic [7:0] bmem [NBYTES];
    logic [1:0] last_status = 2'b00;

    typedef struct {
        logic        rnw;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    dmem_sized #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rnw      (req_rnw),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .status       (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h00;
    endfunction

    // Reference: little-endian byte array, natural alignment, explicit range bound.
    function automatic void model(input logic rnw, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        int unsigned n;
        logic [63:0] val;
        rdata = 32'd0;
        err   = 1'b0;
        n     = 1;
        if (size == 2'b11) begin
            err = 1'b1;
        end else begin
            n = 32'd1 << size;
            if ((addr % n) != 0 || addr >= NBYTES) err = 1'b1;
        end
        if (!err) begin
            if (rnw) begin
                val = 64'd0;
                for (int i = 0; i < int'(n); i++) val = val + (64'(bmem[addr + i]) << (8 * i));
                rdata = val[31:0];
                if (!uns && n < 4 && val[8*n-1]) rdata = rdata | (32'hFFFF_FFFF << (8 * n));
            end else begin
                for (int i = 0; i < int'(n); i++) bmem[addr + i] = 8'(wdata >> (8 * i));
            end
        end
    endfunction

    task automatic issue(input logic rnw, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        logic [1:0] exp_status;
        req_valid = 1'b1;
        req_rnw = rnw; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_status = exp_err ? 2'b10 : 2'b01;
        check({tag, "_valid"},  32'(rsp_valid), 32'd1);
        check({tag, "_rdata"},  rsp_rdata, exp_rdata);
        check({tag, "_err"},    32'(rsp_err), 32'(exp_err));
        check({tag, "_status"}, 32'(status), 32'(exp_status));
        last_status = exp_status;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check("idle_valid", 32'(rsp_valid), 32'd0);
        check("idle_status_hold", 32'(status), 32'(last_status));
    endtask

    // Count cycles until req_ready, checking status reads INIT throughout.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        model_clear();
        last_status = 2'b00;
        while (!req_ready && n < 200) begin
            check({tag, "_init_status"}, 32'(status), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_init_cycles"}, 32'(n), 32'(DEPTH));
    endtask

    function automatic void add(input logic rnw, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vecs.push_back('{rnw, size, uns, addr, wdata, exp_rdata, exp_err});
    endfunction

    initial begin
        logic [31:0] m_rdata;
        logic        m_err;
        logic        rnw, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;

        // rnw size uns addr wdata exp_rdata exp_err
        add(1'b1, 2'b10, 1'b0, 32'h3C, 32'h0,         32'h0000_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h08, 32'h1122_3344, 32'h0000_0000, 1'b0);
        add(1'b0, 2'b00, 1'b0, 32'h0A, 32'h0000_00AA, 32'h0000_0000, 1'b0);
        add(1'b1, 2'b10, 1'b0, 32'h08, 32'h0,         32'h11AA_3344, 1'b0);
        add(1'b1, 2'b00, 1'b0, 32'h0A, 32'h0,         32'hFFFF_FFAA, 1'b0);
        add(1'b1, 2'b00, 1'b1, 32'h0A, 32'h0,         32'h0000_00AA, 1'b0);
        add(1'b0, 2'b01, 1'b0, 32'h06, 32'h0000_8001, 32'h0000_0000, 1'b0);
        add(1'b1, 2'b01, 1'b0, 32'h06, 32'h0,         32'hFFFF_8001, 1'b0);
        add(1'b1, 2'b01, 1'b1, 32'h06, 32'h0,         32'h0000_8001, 1'b0);
        add(1'b1, 2'b10, 1'b0, 32'h04, 32'h0,         32'h8001_0000, 1'b0);
        add(1'b1, 2'b10, 1'b0, 32'h05, 32'h0,         32'h0000_0000, 1'b1);
        add(1'b0, 2'b01, 1'b0, 32'h03, 32'h0000_1234, 32'h0000_0000, 1'b1);
        add(1'b1, 2'b11, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 1'b1);
        add(1'b1, 2'b10, 1'b0, 32'h40, 32'h0,         32'h0000_0000, 1'b1);
        add(1'b0, 2'b11, 1'b0, 32'h04, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        add(1'b1, 2'b10, 1'b0, 32'h04, 32'h0,         32'h8001_0000, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h00, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        add(1'b1, 2'b10, 1'b0, 32'h00, 32'h0,         32'hDEAD_BEEF, 1'b0);
        add(1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h0000_0000, 1'b1);
        add(1'b0, 2'b00, 1'b0, 32'h8000_0001, 32'h55, 32'h0000_0000, 1'b1);
        add(1'b1, 2'b10, 1'b0, 32'h00, 32'h0,         32'hDEAD_BEEF, 1'b0);
        add(1'b1, 2'b00, 1'b0, 32'h03, 32'h0,         32'hFFFF_FFDE, 1'b0);

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  32'(req_ready), 32'd0);
        check("rst_valid",  32'(rsp_valid), 32'd0);
        check("rst_rdata",  rsp_rdata, 32'd0);
        check("rst_err",    32'(rsp_err), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        reset_n = 1'b1;
        wait_init("boot");

        // Directed table, issued back-to-back.
        foreach (vecs[i]) begin
            model(vecs[i].rnw, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, m_rdata, m_err);
            issue(vecs[i].rnw, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
        end
        idle_cycle();
        idle_cycle();

        // Reset pulse with a response in flight.
        model(1'b0, 2'b10, 1'b0, 32'h08, 32'h1234_5678, m_rdata, m_err);
        issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h1234_5678, 32'h0, 1'b0, "pre_rst_sw");
        req_valid = 1'b1; req_rnw = 1'b1; req_size = 2'b10; req_addr = 32'h08;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_valid_drop", 32'(rsp_valid), 32'd0);
        check("midrst_ready_drop", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_init("rerun");
        model(1'b1, 2'b10, 1'b0, 32'h08, 32'h0, m_rdata, m_err);
        issue(1'b1, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, "post_rst_lw");

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                rnw   = 1'($urandom_range(0, 1));
                uns   = 1'($urandom_range(0, 1));
                size  = 2'($urandom_range(0, 3));
                addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 7));
                wdata = $urandom;
                model(rnw, size, uns, addr, wdata, m_rdata, m_err);
                issue(rnw, size, uns, addr, wdata, m_rdata, m_err, $sformatf("rnd%0d", k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised successor data memory for the single-cycle datapath: a word-organised array with byte, halfword and word loads and stores, sign/zero extension, a valid/ready request port and a one-cycle registered response. After reset it zero-fills itself with a hardware init sequencer. Misaligned, illegal-size and out-of-range accesses are reported per access instead of silently aliasing. It sits between the ALU address output and the writeback mux.

## Interface
- `DEPTH`, default 1024: number of 32-bit words; power of two, 4..65536.
- `ADDR_W`, default 32: byte-address width; must be ≥ log2(DEPTH)+2.
- `clk`, input, 1: single clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid`, input, 1: access request.
- `req_ready`, output, 1: block accepts the request this cycle.
- `req_rnw`, input, 1: 1 = load, 0 = store.
- `req_size`, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`, input, 1: zero-extend loads (LBU/LHU); ignored for word and store.
- `req_addr`, input, ADDR_W: byte address.
- `req_wdata`, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`, output, 1: response for the request accepted last cycle.
- `rsp_rdata`, output, 32: extended load data; 0 for stores and errors.
- `rsp_err`, output, 1: access faulted.
- `status`, output, 2: 00 INIT, 01 READY, 10 READY with sticky fault (last response had `rsp_err`).

## Operation
- FSM states: INIT and RUN.
  - Reset enters INIT with the clear counter at 0.
  - INIT writes 0 to word `cnt` each cycle, `cnt` += 1. After word DEPTH-1 is written, the next state is RUN. INIT takes exactly DEPTH cycles.
- `req_ready` = 1 only in RUN. A request is accepted when `req_valid & req_ready`. Requests during INIT are ignored: no response, no side effect.
- Word index = `req_addr[log2(DEPTH)+1:2]`. Lane = `req_addr[1:0]`.
- Fault if any of the following holds:
  - `req_size` = 11.
  - Half access with `addr[0]` = 1.
  - Word access with `addr[1:0]` ≠ 0.
  - Any address bit above the index field is nonzero.
- A faulting access leaves memory unchanged and returns `rsp_err` = 1, `rsp_rdata` = 0.
- Store behaviour:
  - Byte store writes `wdata[7:0]` into lane bits [8k+7:8k].
  - Half store writes `wdata[15:0]` into the lane pair k, k+1.
  - Word store writes all 32 bits.
  - Other bytes of the word are preserved.
- Load behaviour: extract the lane, then sign-extend from bit 7 or 15 unless `req_unsigned` is set.
- `status` updates with every response: 01 on a clean response, 10 on a faulted one. It holds between accesses and reads 00 throughout INIT.

## Timing
- Reset values: `req_ready` 0, `rsp_valid` 0, `rsp_rdata` 0, `rsp_err` 0, `status` 00.
- Latency is fixed at 1 cycle. A request accepted at edge t produces `rsp_valid` = 1 after edge t, for exactly one cycle.
- Stores also produce a response (ack).
- No response backpressure. Back-to-back requests are accepted every cycle in RUN, giving one response per cycle.
- The store array write commits at the acceptance edge. A load accepted on the following cycle to the same word returns the new data; no bypass is needed.
- Asserting `reset_n` low mid-INIT or mid-RUN immediately drops `rsp_valid`/`req_ready`. Any in-flight response is lost. Release restarts INIT from word 0 and re-clears the whole array.
- The first `req_ready` = 1 occurs DEPTH cycles after the first rising edge with `reset_n` high.

## Structure
- Shared package `dmem_pkg` holds:
  - Size encodings `SZ_B`/`SZ_H`/`SZ_W`.
  - FSM state enum.
  - Status codes `ST_INIT`/`ST_READY`/`ST_FAULT`.
- Sub-module `dmem_lane_align` (combinational) does store lane merge (old word, wdata, size, lane → new word) and load extract/extend. The top level holds the array, FSM, init counter, fault checks and response registers.

## Test plan
- Reset, DEPTH=16: `req_ready` low for exactly 16 cycles and `status`=00. Then LW addr 0x3C returns 0x00000000, `rsp_err`=0, `status`=01.
- SW 0x11223344 @0x8, then SB 0xAA @0xA: LW 0x8 returns 0x11AA3344. LB 0xA returns 0xFFFFFFAA; LBU 0xA returns 0x000000AA.
- SH 0x8001 @0x6: LH 0x6 returns 0xFFFF8001; LHU 0x6 returns 0x00008001; LW 0x4 returns 0x80010000.
- Faults: LW 0x5, SH 0x3, size=11, and LW 0x40 (DEPTH=16) each give `rsp_err`=1, rdata 0, `status`=10. A follow-up LW 0x4 still returns 0x80010000 and `status` returns to 01.
- Back-to-back: SW 0xDEADBEEF @0x0 on cycle t, LW 0x0 on t+1. Responses arrive on t+1 and t+2, and the t+2 data is 0xDEADBEEF.
- `reset_n` pulsed low for 1 cycle mid-stream: no `rsp_valid` for the in-flight request, INIT reruns for 16 cycles, and LW 0x8 afterwards returns 0.
